dmem_addr_unit: RTL and testbench

Data-memory responder for the control unit's memory strobes. Holds the memory address register (MAR) and a row/column index pair for matrix traversal, and forms effective addresses from them. Executes single-cycle-strobe read and write requests against a synchronous data memory with fixed read latency. Sits between the control unit, the data bus, and the data memory macro.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_addr_unit_if.sv | 21 ++
 rtl/dmem_addr_unit_wrap_counter.sv | 38 +++
 rtl/dmem_addr_unit.sv | 170 +++++++++++++++++
 tb/tb_dmem_addr_unit.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and width helpers for the data-memory address unit.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2
  } dmem_state_e;

  // Latency counter must hold MEM_LAT itself; it counts down to zero.
  function automatic int lat_cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_addr_unit_if.sv
// Bus between the address unit (master) and the synchronous data memory macro (slave).
interface dmem_addr_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_addr_unit_wrap_counter.sv
// Modulo counter used for the row and column indices; clear beats increment.
module wrap_counter #(
  parameter int WIDTH   = 2,
  parameter int MODULUS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] value_q, value_d;

  // NOTE: assign a default first so every path writes value_d and no latch is inferred.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = (value_q == LAST) ? '0 : value_q + WIDTH'(1);
    end
  end

  // NOTE: state flops use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/dmem_addr_unit.sv
// Data-memory responder: MAR plus row/column effective-address generation and a
// read/write sequencer against a fixed-latency synchronous memory.
module dmem_addr_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mar_load,
  input  logic [ADDR_W-1:0] mar_in,
  input  logic              mar_inc,
  input  logic              col_inc,
  input  logic              col_zero,
  input  logic              row_inc,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              req_err,
  dmem_addr_unit_if.master  mem
);

  localparam int CNT_W = lat_cnt_w(MEM_LAT);
  localparam int ROW_W = idx_w(ROWS);
  localparam int COL_W = idx_w(COLS);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);

  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ROW_W-1:0]  row_idx;
  logic [COL_W-1:0]  col_idx;
  logic [ADDR_W-1:0] ea;

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              req_err_q, req_err_d;

  logic              rd_done;
  logic              accept_ok;

  wrap_counter #(.WIDTH(ROW_W), .MODULUS(ROWS)) u_row (
    .clk   (clk),
    .reset (reset),
    .inc   (row_inc),
    .clr   (1'b0),
    .value (row_idx)
  );

  wrap_counter #(.WIDTH(COL_W), .MODULUS(COLS)) u_col (
    .clk   (clk),
    .reset (reset),
    .inc   (col_inc),
    .clr   (col_zero),
    .value (col_idx)
  );

  always_comb begin
    mar_d = mar_q;
    if (mar_load) begin
      mar_d = mar_in;
    end else if (mar_inc) begin
      mar_d = mar_q + ADDR_W'(1);
    end
  end

  // Uses the registered indices, so a same-cycle index strobe does not affect this access.
  assign ea = mar_q + ADDR_W'(row_idx) * ADDR_W'(COLS) + ADDR_W'(col_idx);

  // The final cycle of an access can hand over directly to the next request.
  assign rd_done   = (state_q == RD_WAIT) && (cnt_q == '0);
  assign accept_ok = (state_q == IDLE) || (state_q == WR) || rd_done;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_re_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    req_err_d     = req_err_q;

    case (state_q)
      RD_WAIT: begin
        if (rd_done) begin
          rdata_d       = mem.mem_rdata;
          rdata_valid_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR:      state_d = IDLE;
      default: ;
    endcase

    if (accept_ok) begin
      if (dmem_write) begin
        state_d     = WR;
        mem_we_d    = 1'b1;
        mem_addr_d  = ea;
        mem_wdata_d = wdata;
        if (dmem_read) begin
          req_err_d = 1'b1;
        end
      end else if (dmem_read) begin
        state_d    = RD_WAIT;
        cnt_d      = LAT_INIT;
        mem_re_d   = 1'b1;
        mem_addr_d = ea;
      end
    end else if (dmem_read || dmem_write) begin
      req_err_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mar_q         <= '0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      req_err_q     <= 1'b0;
    end else begin
      mar_q         <= mar_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      req_err_q     <= req_err_d;
    end
  end

  assign busy          = busy_q;
  assign rdata         = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign req_err       = req_err_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_re    = mem_re_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_addr_unit.sv
// Bench for dmem_addr_unit: directed scenarios then random traffic, all against a
// transaction-timeline reference model and a latency-pipelined memory model.
module tb_dmem_addr_unit;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int NR   = 4;
  localparam int NC   = 4;
  localparam int LAT  = 2;

  typedef struct {
    bit          mar_load;
    bit [AW-1:0] mar_in;
    bit          mar_inc;
    bit          col_inc;
    bit          col_zero;
    bit          row_inc;
    bit          rd;
    bit          wr;
    bit [DW-1:0] wdata;
  } stim_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mar_load = 1'b0, mar_inc = 1'b0, col_inc = 1'b0, col_zero = 1'b0, row_inc = 1'b0;
  logic [AW-1:0] mar_in = '0;
  logic          dmem_read = 1'b0, dmem_write = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          busy, rdata_valid, req_err;
  logic [DW-1:0] rdata;

  dmem_addr_unit_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

  dmem_addr_unit #(
    .ADDR_W(AW), .DATA_W(DW), .ROWS(NR), .COLS(NC), .MEM_LAT(LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mar_load    (mar_load),
    .mar_in      (mar_in),
    .mar_inc     (mar_inc),
    .col_inc     (col_inc),
    .col_zero    (col_zero),
    .row_inc     (row_inc),
    .dmem_read   (dmem_read),
    .dmem_write  (dmem_write),
    .wdata       (wdata),
    .busy        (busy),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .req_err     (req_err),
    .mem         (mem_bus)
  );

  always #5 clk = ~clk;

  // Memory: background pattern plus written words, read data delayed LAT edges.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a * 16'd7) ^ 16'h5A5A;
  endfunction

  logic [DW-1:0] mem_wr [int];
  logic [DW-1:0] pipe [LAT];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return mem_wr.exists(int'(a)) ? mem_wr[int'(a)] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_bus.mem_we) mem_wr[int'(mem_bus.mem_addr)] = mem_bus.mem_wdata;
    if (mem_bus.mem_re) pipe[0] <= mem_word(mem_bus.mem_addr);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_bus.mem_rdata = pipe[LAT-1];

  // Reference model: edge-indexed timeline of accepted transactions.
  int            n_checks = 0, n_pass = 0;
  int            edge_n = 0, m_free = 0, m_done = -1;
  int            m_row = 0, m_col = 0;
  logic [AW-1:0] m_mar = '0, m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0, m_pending = '0;
  logic          m_re = 0, m_we = 0, m_busy = 0, m_valid = 0, m_err = 0;
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_mar = '0; m_row = 0; m_col = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    m_re = 0; m_we = 0; m_busy = 0; m_valid = 0; m_err = 0;
    m_free = edge_n; m_done = -1;
  endtask

  task automatic model_step(input stim_t s);
    logic [AW-1:0] ea;
    edge_n++;
    ea = m_mar + AW'(m_row * NC + m_col);
    m_valid = (edge_n == m_done);
    if (m_valid) m_rdata = m_pending;
    m_re = 0;
    m_we = 0;
    if (edge_n >= m_free) begin
      if (s.wr) begin
        m_we = 1; m_addr = ea; m_wdata = s.wdata;
        ref_mem[int'(ea)] = s.wdata;
        m_free = edge_n + 1;
        if (s.rd) m_err = 1;
      end else if (s.rd) begin
        m_re = 1; m_addr = ea;
        m_free = edge_n + 1 + LAT;
        m_done = m_free;
        m_pending = ref_word(ea);
      end
    end else if (s.rd || s.wr) begin
      m_err = 1;
    end
    m_busy = (edge_n < m_free);
    if (s.mar_load) m_mar = s.mar_in;
    else if (s.mar_inc) m_mar = m_mar + 1'b1;
    if (s.col_zero) m_col = 0;
    else if (s.col_inc) m_col = (m_col + 1) % NC;
    if (s.row_inc) m_row = (m_row + 1) % NR;
  endtask

  task automatic check_all();
    check("busy", busy, m_busy);
    check("mem_re", mem_bus.mem_re, m_re);
    check("mem_we", mem_bus.mem_we, m_we);
    check("mem_addr", mem_bus.mem_addr, m_addr);
    check("rdata_valid", rdata_valid, m_valid);
    check("rdata", rdata, m_rdata);
    check("req_err", req_err, m_err);
    if (m_we) check("mem_wdata", mem_bus.mem_wdata, m_wdata);
  endtask

  // Drive right after a falling edge, model the rising edge, check at the next falling edge.
  task automatic cycle(input stim_t s);
    mar_load = s.mar_load; mar_in = s.mar_in; mar_inc = s.mar_inc;
    col_inc = s.col_inc; col_zero = s.col_zero; row_inc = s.row_inc;
    dmem_read = s.rd; dmem_write = s.wr; wdata = s.wdata;
    @(posedge clk);
    model_step(s);
    @(negedge clk);
    check_all();
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".rdata"}, rdata, 0);
    check({tag, ".rdata_valid"}, rdata_valid, 0);
    check({tag, ".req_err"}, req_err, 0);
    check({tag, ".mem_addr"}, mem_bus.mem_addr, 0);
    check({tag, ".mem_re"}, mem_bus.mem_re, 0);
    check({tag, ".mem_we"}, mem_bus.mem_we, 0);
    check({tag, ".mem_wdata"}, mem_bus.mem_wdata, 0);
  endtask

  initial begin
    stim_t s;
    for (int i = 0; i < LAT; i++) pipe[i] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_zero_outputs("reset");

    // Address formation: 0x0100 + 1*4 + 2 = 0x0106, data after LAT+1 edges.
    s = idle_s(); s.mar_load = 1; s.mar_in = 16'h0100; cycle(s);
    s = idle_s(); s.row_inc = 1; cycle(s);
    s = idle_s(); s.col_inc = 1; cycle(s);
    cycle(s);
    s = idle_s(); s.rd = 1; cycle(s);
    check("rd1.addr", mem_bus.mem_addr, 16'h0106);
    check("rd1.re", mem_bus.mem_re, 1);
    cycle(idle_s());
    check("rd1.re_drop", mem_bus.mem_re, 0);
    cycle(idle_s());
    check("rd1.no_early_valid", rdata_valid, 0);
    cycle(idle_s());
    check("rd1.valid", rdata_valid, 1);
    check("rd1.data", rdata, init_word(16'h0106));
    cycle(idle_s());

    // Write at MAR 0x0020 with row walked 1 -> 2 -> 3 -> 0.
    s = idle_s(); s.mar_load = 1; s.mar_in = 16'h0020; s.col_zero = 1; s.row_inc = 1; cycle(s);
    s = idle_s(); s.row_inc = 1; cycle(s);
    cycle(s);
    s = idle_s(); s.wr = 1; s.wdata = 16'hBEEF; cycle(s);
    check("wr.we", mem_bus.mem_we, 1);
    check("wr.addr", mem_bus.mem_addr, 16'h0020);
    check("wr.wdata", mem_bus.mem_wdata, 16'hBEEF);
    cycle(idle_s());
    check("wr.busy_low", busy, 0);

    // Column wrap after four increments, and clear beating increment.
    s = idle_s(); s.col_inc = 1;
    repeat (4) cycle(s);
    s = idle_s(); s.rd = 1; cycle(s);
    check("colwrap.addr", mem_bus.mem_addr, 16'h0020);
    repeat (LAT + 1) cycle(idle_s());
    check("colwrap.data", rdata, 16'hBEEF);
    s = idle_s(); s.col_inc = 1; cycle(s);
    s.col_zero = 1; cycle(s);
    s = idle_s(); s.rd = 1; cycle(s);
    check("colzero.addr", mem_bus.mem_addr, 16'h0020);
    repeat (LAT + 2) cycle(idle_s());

    // Dropped requests: read while waiting, then both strobes together.
    check("err.clear", req_err, 0);
    s = idle_s(); s.rd = 1; cycle(s);
    cycle(s);
    check("err.rd_busy", req_err, 1);
    repeat (LAT + 1) cycle(idle_s());
    s = idle_s(); s.rd = 1; s.wr = 1; s.wdata = 16'h1234; cycle(s);
    check("both.we", mem_bus.mem_we, 1);
    check("both.re", mem_bus.mem_re, 0);
    cycle(idle_s());
    cycle(idle_s());
    check("err.sticky", req_err, 1);

    // Address wrap: 0xFFFF + 3*4 + 3 = 0x1000E -> 0x000E.
    s = idle_s(); s.mar_load = 1; s.mar_in = 16'hFFFF; s.row_inc = 1; s.col_inc = 1; cycle(s);
    s = idle_s(); s.row_inc = 1; s.col_inc = 1;
    repeat (2) cycle(s);
    s = idle_s(); s.rd = 1; cycle(s);
    check("wrap.addr", mem_bus.mem_addr, 16'h000E);
    cycle(idle_s());

    // Reset in the middle of a read wait.
    reset = 1'b1;
    #1;
    model_reset();
    check_zero_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (LAT + 3) cycle(idle_s());
    check("midrst.no_valid", rdata_valid, 0);

    // Random traffic; strobes only when clearly idle or clearly mid-access.
    for (int n = 0; n < 500; n++) begin
      s = idle_s();
      s.mar_load = ($urandom_range(7) == 0);
      s.mar_in   = AW'($urandom);
      s.mar_inc  = ($urandom_range(3) == 0);
      s.col_inc  = ($urandom_range(2) == 0);
      s.col_zero = ($urandom_range(7) == 0);
      s.row_inc  = ($urandom_range(3) == 0);
      s.wdata    = DW'($urandom);
      if (edge_n >= m_free) begin
        s.rd = ($urandom_range(2) == 0);
        s.wr = ($urandom_range(3) == 0);
      end else if (edge_n + 1 < m_free) begin
        s.rd = ($urandom_range(15) == 0);
        s.wr = ($urandom_range(15) == 0);
      end
      cycle(s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
